// File: rtl/datapath_execute_memreg.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution and redirect target,
// followed by the EX/MEM pipeline register that feeds the memory stage.
module datapath_execute_memreg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      Rs1E,
  input  logic [4:0]      Rs2E,
  input  logic [4:0]      RdE,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic            JalrE,
  input  logic [1:0]      ResultSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [2:0]      funct3E,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [4:0]      RdM,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM
);

  logic [XLEN-1:0] r_alu_result_m;
  logic [XLEN-1:0] r_write_data_m;
  logic [XLEN-1:0] r_pc_plus4_m;
  logic [4:0]      r_rd_m;
  logic            r_reg_write_m;
  logic            r_mem_write_m;
  logic [1:0]      r_result_src_m;

  logic [XLEN-1:0] w_src_a;
  logic [XLEN-1:0] w_write_data_e;
  logic [XLEN-1:0] w_src_b;
  logic [XLEN-1:0] w_alu_result;
  logic            w_taken;
  logic            w_lt_signed;
  logic            w_lt_unsigned;
  logic            w_alu_lt;

  // MEM wins over WB; writes to x0 are never forwarded.
  always_comb begin
    ForwardAE = 2'b00;
    if (r_reg_write_m && (r_rd_m != 5'd0) && (r_rd_m == Rs1E))
      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
      ForwardAE = 2'b01;

    ForwardBE = 2'b00;
    if (r_reg_write_m && (r_rd_m != 5'd0) && (r_rd_m == Rs2E))
      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
      ForwardBE = 2'b01;
  end

  always_comb begin
    case (ForwardAE)
      2'b01:   w_src_a = ResultW;
      2'b10:   w_src_a = r_alu_result_m;
      default: w_src_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   w_write_data_e = ResultW;
      2'b10:   w_write_data_e = r_alu_result_m;
      default: w_write_data_e = RD2E;
    endcase
  end

  assign w_src_b  = ALUSrcE ? ImmExtE : w_write_data_e;
  assign w_alu_lt = $signed(w_src_a) < $signed(w_src_b);

  always_comb begin
    case (ALUControlE)
      3'b000:  w_alu_result = w_src_a + w_src_b;
      3'b001:  w_alu_result = w_src_a - w_src_b;
      3'b010:  w_alu_result = w_src_a & w_src_b;
      3'b011:  w_alu_result = w_src_a | w_src_b;
      3'b100:  w_alu_result = w_src_a ^ w_src_b;
      3'b101:  w_alu_result = {{(XLEN-1){1'b0}}, w_alu_lt};
      3'b110:  w_alu_result = w_src_a << w_src_b[4:0];
      default: w_alu_result = w_src_a >> w_src_b[4:0];
    endcase
  end

  // Branch compares the register operands, never the immediate.
  assign w_lt_signed   = $signed(w_src_a) < $signed(w_write_data_e);
  assign w_lt_unsigned = w_src_a < w_write_data_e;

  always_comb begin
    case (funct3E)
      3'b000:  w_taken = (w_src_a == w_write_data_e);
      3'b001:  w_taken = (w_src_a != w_write_data_e);
      3'b100:  w_taken = w_lt_signed;
      3'b101:  w_taken = ~w_lt_signed;
      3'b110:  w_taken = w_lt_unsigned;
      3'b111:  w_taken = ~w_lt_unsigned;
      default: w_taken = 1'b0;
    endcase
  end

  assign PCSrcE    = JumpE | (BranchE & w_taken);
  assign PCTargetE = JalrE ? ((w_src_a + ImmExtE) & ~{{(XLEN-1){1'b0}}, 1'b1})
                           : (PCE + ImmExtE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alu_result_m <= '0;
      r_write_data_m <= '0;
      r_pc_plus4_m   <= '0;
      r_rd_m         <= '0;
      r_reg_write_m  <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_result_src_m <= '0;
    end else begin
      r_alu_result_m <= w_alu_result;
      r_write_data_m <= w_write_data_e;
      r_pc_plus4_m   <= PCPlus4E;
      r_rd_m         <= RdE;
      r_reg_write_m  <= RegWriteE;
      r_mem_write_m  <= MemWriteE;
      r_result_src_m <= ResultSrcE;
    end
  end

  assign ALUResultM = r_alu_result_m;
  assign WriteDataM = r_write_data_m;
  assign PCPlus4M   = r_pc_plus4_m;
  assign RdM        = r_rd_m;
  assign RegWriteM  = r_reg_write_m;
  assign MemWriteM  = r_mem_write_m;
  assign ResultSrcM = r_result_src_m;

endmodule
